// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master: streams a contiguous SDRAM region of 64-bit words
// through a show-ahead FIFO to a valid/ready consumer.
module sdram_burst_reader #(
   parameter int BURST_LENGTH = 32,
   parameter int FIFO_DEPTH   = 128
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [28:0]                   base_address,
   input  logic [23:0]                   word_count,
   output logic                          busy,
   output logic                          done,
   output logic [28:0]                   address,
   output logic [7:0]                    burstcount,
   output logic                          read,
   input  logic                          waitrequest,
   input  logic [63:0]                   readdata,
   input  logic                          readdatavalid,
   output logic [7:0]                    byteenable,
   output logic [63:0]                   out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [1:0]                    fsm_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   state_t          cur, nxt;
   logic [63:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level, outstanding;
   logic [23:0]     unreq, len_src;
   logic [7:0]      next_len;
   logic            push, pop, accept, can_issue;
   logic            launch, finish, zero_done;

   assign byteenable = 8'hFF;
   assign busy       = (cur != IDLE);
   assign fsm_state  = cur;
   assign fifo_level = level;
   assign out_valid  = (level != '0);
   assign out_data   = out_valid ? mem[rd_ptr] : '0;

   // Words arriving with nothing outstanding are leftovers from before a reset.
   assign push      = readdatavalid && (outstanding != '0);
   assign pop       = out_valid && out_ready;
   assign accept    = read && !waitrequest;
   assign len_src   = (cur == IDLE) ? word_count : unreq;
   assign next_len  = (len_src >= 24'(BURST_LENGTH)) ? 8'(BURST_LENGTH) : len_src[7:0];
   assign can_issue = (32'(level) + 32'(outstanding) + 32'(next_len)) <= 32'(FIFO_DEPTH);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cur <= IDLE;
      else          cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:    if (start && word_count != '0) nxt = ISSUE;
         ISSUE:   if (accept && unreq == 24'(burstcount)) nxt = DRAIN;
         DRAIN:   if (outstanding == '0 && (level == '0 || (level == LW'(1) && pop))) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      launch    = 1'b0;
      finish    = 1'b0;
      zero_done = 1'b0;
      case (cur)
         IDLE: begin
            launch    = start && (word_count != '0);
            zero_done = start && (word_count == '0);
         end
         ISSUE:   launch = !read && can_issue;
         DRAIN:   finish = (nxt == IDLE);
         default: ;
      endcase
   end

   // Request registers only move on launch or acceptance, so they hold through a stall.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read        <= 1'b0;
         address     <= '0;
         burstcount  <= '0;
         unreq       <= '0;
         outstanding <= '0;
         done        <= 1'b0;
      end else begin
         done <= finish || zero_done;
         if (launch) begin
            read       <= 1'b1;
            burstcount <= next_len;
            if (cur == IDLE) begin
               address <= base_address;
               unreq   <= word_count;
            end
         end else if (accept) begin
            read    <= 1'b0;
            address <= address + 29'(burstcount);
            unreq   <= unreq - 24'(burstcount);
         end
         outstanding <= outstanding + (accept ? LW'(burstcount) : LW'(0)) - (push ? LW'(1) : LW'(0));
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= readdata;
   end

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Bench for sdram_burst_reader: Avalon memory model, transfer-level reference model
// and scoreboard, directed cases followed by randomized transfers.
module tb_sdram_burst_reader;

   localparam int BL    = 32;
   localparam int DEPTH = 64;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset_n, start, waitrequest, readdatavalid, out_ready;
   logic [28:0]   base_address, address;
   logic [23:0]   word_count;
   logic [7:0]    burstcount, byteenable;
   logic [63:0]   readdata, out_data;
   logic          busy, done, read, out_valid;
   logic [LW-1:0] fifo_level;
   logic [1:0]    fsm_state;

   int n_cmp = 0, n_err = 0;
   int cyc = 0, lat = 5, n_acc = 0;
   logic hold_wait = 0, rand_wait = 0, rand_gap = 0, rand_ready = 0;

   // reference model state
   logic [63:0] exp_q[$];
   logic [36:0] exp_burst_q[$];
   logic [28:0] pend_addr[$];
   int          pend_due[$];
   logic m_busy = 0, m_done = 0, first_read = 0;
   int   m_level = 0, m_out = 0, m_left = 0;
   logic prev_stall = 0, prev_acc = 0, prev_read = 0;
   logic [28:0] prev_addr = '0;
   logic [7:0]  prev_bc = '0;

   sdram_burst_reader #(.BURST_LENGTH(BL), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .base_address(base_address),
      .word_count(word_count), .busy(busy), .done(done), .address(address),
      .burstcount(burstcount), .read(read), .waitrequest(waitrequest), .readdata(readdata),
      .readdatavalid(readdatavalid), .byteenable(byteenable), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   initial begin
      #800_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [28:0] a);
      return {3'b101, a, 3'b010, ~a};
   endfunction

   // Expected bursts and words of one transfer, straight from the burst-splitting rule.
   task automatic plan(input logic [28:0] b, input int n);
      int          rem;
      logic [28:0] a;
      rem = n;
      a   = b;
      for (int i = 0; i < n; i++) exp_q.push_back(word_of(b + 29'(i)));
      while (rem > 0) begin
         int len;
         len = (rem < BL) ? rem : BL;
         exp_burst_q.push_back({8'(len), a});
         a   = a + 29'(len);
         rem = rem - len;
      end
   endtask

   // Avalon slave: captures accepted requests, returns word_of(addr) after lat cycles.
   initial begin : slave
      waitrequest   = 1'b0;
      readdatavalid = 1'b0;
      readdata      = '0;
      forever begin
         @(negedge clock);
         if (reset_n && read && !waitrequest) begin
            for (int i = 0; i < int'(burstcount); i++) begin
               pend_addr.push_back(address + 29'(i));
               pend_due.push_back(cyc + lat);
            end
         end
         @(posedge clock);
         #1;
         cyc++;
         readdatavalid = 1'b0;
         readdata      = '0;
         if (pend_addr.size() != 0 && pend_due[0] <= cyc && !(rand_gap && $urandom_range(0, 3) == 0)) begin
            readdatavalid = 1'b1;
            readdata      = word_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         waitrequest = hold_wait ? 1'b1 : (rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0);
      end
   end

   initial begin : ready_gen
      forever begin
         @(posedge clock);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin : monitor
      logic [36:0] eb;
      logic [63:0] ew;
      logic        push_now, pop_now, nxt_done, was_busy;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            check("rst_read", 64'(read), 64'd0);
            check("rst_address", 64'(address), 64'd0);
            check("rst_burstcount", 64'(burstcount), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_fifo_level", 64'(fifo_level), 64'd0);
            m_busy = 0; m_done = 0; first_read = 0;
            m_level = 0; m_out = 0; m_left = 0;
            prev_stall = 0; prev_acc = 0; prev_read = 0;
            exp_q.delete();
            exp_burst_q.delete();
         end else begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("fifo_level", 64'(fifo_level), 64'(m_level));
            check("out_valid", 64'(out_valid), 64'(m_level != 0));
            check("byteenable", 64'(byteenable), 64'hFF);
            if (!m_busy) check("read_idle", 64'(read), 64'd0);
            if (first_read) check("first_read", 64'(read), 64'd1);
            if (prev_stall) begin
               check("stall_read", 64'(read), 64'd1);
               check("stall_address", 64'(address), 64'(prev_addr));
               check("stall_burstcount", 64'(burstcount), 64'(prev_bc));
            end
            if (prev_acc) check("read_gap", 64'(read), 64'd0);
            if (read && !prev_read)
               check("flow_limit", 64'(m_level + m_out + int'(burstcount) <= DEPTH), 64'd1);

            was_busy   = m_busy;
            nxt_done   = 1'b0;
            first_read = 1'b0;
            push_now   = readdatavalid && (m_out > 0);
            pop_now    = (m_level > 0) && out_ready;
            if (read && !waitrequest) begin
               check("burst_expected", 64'(exp_burst_q.size() != 0), 64'd1);
               if (exp_burst_q.size() != 0) begin
                  eb = exp_burst_q.pop_front();
                  check("burst_address", 64'(address), 64'(eb[28:0]));
                  check("burstcount", 64'(burstcount), 64'(eb[36:29]));
                  m_out = m_out + int'(eb[36:29]);
               end
               n_acc++;
            end
            if (pop_now) begin
               check("word_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  ew = exp_q.pop_front();
                  check("out_data", out_data, ew);
               end
               m_left--;
               if (m_left == 0 && m_busy) begin
                  m_busy   = 1'b0;
                  nxt_done = 1'b1;
               end
               m_level--;
            end
            if (push_now) begin
               m_out--;
               m_level++;
            end
            if (start && !was_busy) begin
               if (word_count == '0) nxt_done = 1'b1;
               else begin
                  m_busy     = 1'b1;
                  first_read = 1'b1;
                  m_left     = int'(word_count);
                  plan(base_address, int'(word_count));
               end
            end
            prev_stall = read && waitrequest;
            prev_acc   = read && !waitrequest;
            prev_read  = read;
            prev_addr  = address;
            prev_bc    = burstcount;
            m_done     = nxt_done;
         end
      end
   end

   task automatic do_start(input logic [28:0] b, input int n);
      @(posedge clock);
      #1;
      base_address = b;
      word_count   = 24'(n);
      start        = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int c;
      c = 0;
      while ((m_busy || m_done || exp_q.size() != 0) && c < budget) begin
         @(posedge clock);
         c++;
      end
      #1;
      check({tag, "_in_time"}, 64'(c < budget), 64'd1);
      check({tag, "_bursts_left"}, 64'(exp_burst_q.size()), 64'd0);
      check({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin : main
      int acc0, c, n;
      logic [28:0] b;
      reset_n = 1'b0; start = 1'b0; base_address = '0; word_count = '0; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // basic and short-final-burst transfers
      out_ready = 1'b1;
      acc0 = n_acc;
      do_start(29'h100, 64);
      wait_idle(2000, "basic");
      check("basic_bursts", 64'(n_acc - acc0), 64'd2);
      acc0 = n_acc;
      do_start(29'h180, 70);
      wait_idle(2000, "short");
      check("short_bursts", 64'(n_acc - acc0), 64'd3);

      // waitrequest held on the first burst
      acc0 = n_acc;
      hold_wait = 1'b1;
      do_start(29'h200, 32);
      repeat (9) @(posedge clock);
      #1;
      check("stall_no_accept", 64'(n_acc - acc0), 64'd0);
      check("stall_read_held", 64'(read), 64'd1);
      hold_wait = 1'b0;
      wait_idle(2000, "stall");
      check("stall_bursts", 64'(n_acc - acc0), 64'd1);

      // back-pressure: only two bursts fit while nothing drains
      out_ready = 1'b0;
      acc0 = n_acc;
      do_start(29'h300, 128);
      repeat (80) @(posedge clock);
      #1;
      check("bp_level_full", 64'(fifo_level), 64'(DEPTH));
      check("bp_bursts", 64'(n_acc - acc0), 64'd2);
      check("bp_no_read", 64'(read), 64'd0);
      out_ready = 1'b1;
      wait_idle(2000, "bp");

      // zero-length and address wrap
      do_start(29'h55, 0);
      wait_idle(100, "zero");
      do_start(29'h1FFF_FFF0, 64);
      wait_idle(2000, "wrap");

      // reset while a request is up and words are outstanding
      do_start(29'h800, 128);
      c = 0;
      while (!(read && m_out > 0) && c < 300) begin
         @(posedge clock);
         #1;
         c++;
      end
      check("midrst_reached", 64'(c < 300), 64'd1);
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      c = 0;
      while (pend_addr.size() != 0 && c < 300) begin
         @(posedge clock);
         c++;
      end
      @(negedge clock);
      check("stale_drained", 64'(c < 300), 64'd1);
      check("stale_dropped", 64'(fifo_level), 64'd0);
      do_start(29'h900, 50);
      wait_idle(2000, "after_rst");

      // randomized transfers with stalls, gaps, latency and ready jitter
      rand_wait = 1'b1; rand_gap = 1'b1; rand_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         lat = $urandom_range(2, 8);
         b   = 29'($urandom);
         n   = $urandom_range(1, 200);
         do_start(b, n);
         if (t % 3 == 0) begin
            @(posedge clock);
            #1;
            base_address = 29'($urandom);
            word_count   = 24'd7;
            start        = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
         end
         wait_idle(6000, "rand");
      end
      rand_wait = 1'b0; rand_gap = 1'b0; rand_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
